// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-back front end.
// The entry data width is fixed at XLEN_DEFAULT; the top parameter XLEN must match it.
package regfile_wb_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
        logic                    kill;
    } wb_entry_t;

    // x0 is never a real destination, so it never matches anything.
    function automatic logic rd_hit(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
        return (a == b) && (b != '0);
    endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Circular buffer of pending long-latency results, presented in age order (index 0 = head).
// Entry data and kill bits are exported only when REGFILE_WRITEBACK_BYPASS_EN is defined.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  wb_entry_t                            push_entry,
    input  logic                                 pop,
    input  logic [DEPTH-1:0]                     kill,
    output wb_entry_t                            head,
    output logic [DEPTH-1:0]                     ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_rd,
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    output logic [DEPTH-1:0]                     ent_kill,
    output logic [DEPTH-1:0][XLEN_DEFAULT-1:0]   ent_data,
`endif
    output logic [CW-1:0]                        count,
    output logic                                 full,
    output logic                                 empty
);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DEPTH-1:0]      phys_kill;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Kill requests arrive in age order; map each physical slot to its age.
    for (genvar i = 0; i < DEPTH; i++) begin : g_phys
        logic [PW-1:0] age;
        assign age          = PW'(i) - rd_ptr;
        assign phys_kill[i] = kill[age];
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [PW-1:0] idx;
        assign idx          = rd_ptr + PW'(k);
        assign ent_valid[k] = CW'(k) < count;
        assign ent_rd[k]    = mem[idx].rd;
`ifdef REGFILE_WRITEBACK_BYPASS_EN
        assign ent_kill[k]  = mem[idx].kill;
        assign ent_data[k]  = mem[idx].data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (phys_kill[i]) mem[i].kill <= 1'b1;
            // The push slot is free, so it never collides with a kill above.
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and buffered LSU results onto the single register-file write port.
// Optional read bypass of in-flight/pending writes: define REGFILE_WRITEBACK_BYPASS_EN.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] wr,
    output logic [XLEN-1:0]       wd,
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    input  logic [REG_ADDR_W-1:0] rr1,
    input  logic [REG_ADDR_W-1:0] rr2,
    output logic                  byp1_hit,
    output logic                  byp2_hit,
    output logic [XLEN-1:0]       byp1_data,
    output logic [XLEN-1:0]       byp2_data,
`endif
    output logic [CW-1:0]         pend_count
);

    logic                             alu_write;
    logic                             push;
    logic                             pop;
    logic                             full;
    logic                             empty;
    wb_entry_t                        push_entry;
    wb_entry_t                        head;
    logic [DEPTH-1:0]                 kill;
    logic [DEPTH-1:0]                 ent_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    logic [DEPTH-1:0]                 ent_kill;
    logic [DEPTH-1:0][XLEN-1:0]       ent_data;
`endif

    assign alu_write = alu_valid && (alu_rd != '0);
    assign lsu_ready = !full && !rst;
    assign push      = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign pop       = !alu_write && !empty;

    // A same-cycle LSU push is older than the ALU write, so it is born killed.
    assign push_entry = '{rd: lsu_rd, data: lsu_data, kill: alu_write && (lsu_rd == alu_rd)};

    for (genvar k = 0; k < DEPTH; k++) begin : g_kill
        assign kill[k] = alu_write && ent_valid[k] && (ent_rd[k] == alu_rd);
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (kill),
        .head       (head),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd),
`ifdef REGFILE_WRITEBACK_BYPASS_EN
        .ent_kill   (ent_kill),
        .ent_data   (ent_data),
`endif
        .count      (pend_count),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite <= 1'b0;
            wr       <= '0;
            wd       <= '0;
        end else if (alu_write) begin
            RegWrite <= 1'b1;
            wr       <= alu_rd;
            wd       <= alu_data;
        end else if (pop && !head.kill) begin
            RegWrite <= 1'b1;
            wr       <= head.rd;
            wd       <= head.data;
        end else begin
            RegWrite <= 1'b0;
        end
    end

`ifdef REGFILE_WRITEBACK_BYPASS_EN
    // Younger entries override older ones; the registered output write beats all of them.
    function automatic logic [XLEN:0] byp_lookup(input logic [REG_ADDR_W-1:0] rr);
        logic [XLEN:0] r;
        r = '0;
        for (int k = 0; k < DEPTH; k++)
            if (ent_valid[k] && !ent_kill[k] && rd_hit(ent_rd[k], rr))
                r = {1'b1, ent_data[k]};
        if (RegWrite && rd_hit(wr, rr))
            r = {1'b1, wd};
        return r;
    endfunction

    always_comb begin
        {byp1_hit, byp1_data} = byp_lookup(rr1);
        {byp2_hit, byp2_data} = byp_lookup(rr2);
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench: vector table for single-cycle ALU cases, directed LSU/kill/reset sequences,
// and a scoreboard of expected register-file writes checked on every RegWrite.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        RegWrite;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [2:0]  pend_count;
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    logic [4:0]  rr1, rr2;
    logic        byp1_hit, byp2_hit;
    logic [31:0] byp1_data, byp2_data;
`endif

    regfile_writeback #(.XLEN(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .RegWrite   (RegWrite),
        .wr         (wr),
        .wd         (wd),
`ifdef REGFILE_WRITEBACK_BYPASS_EN
        .rr1        (rr1),
        .rr2        (rr2),
        .byp1_hit   (byp1_hit),
        .byp2_hit   (byp2_hit),
        .byp1_data  (byp1_data),
        .byp2_data  (byp2_data),
`endif
        .pend_count (pend_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        exp_we;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] model_rf [32];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d, input logic expect_write);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
        if (expect_write) sb.push_back('{rd, d});
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d;
    endtask

    // Register-file stand-in: commits on the negedge after RegWrite, checks order and content.
    always @(negedge clk) begin
        exp_t e;
        if (RegWrite === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual wr=%0d wd=%h expected no write", wr, wd);
            end else begin
                e = sb.pop_front();
                check("sb_wr", {27'd0, wr}, {27'd0, e.rd});
                check("sb_wd", wd, e.data);
                if (wr != 5'd0) model_rf[wr] = wd;
            end
        end
    end

    initial begin
        vec_t vecs[6];
        logic [4:0]  byp_rd [3];
        logic [31:0] byp_d  [3];

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0};
        vecs[2] = '{1'b0, 5'd3,  32'h00000055, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1};
        vecs[5] = '{1'b1, 5'd0,  32'h00000000, 1'b0};
        byp_rd  = '{5'd6, 5'd22, 5'd23};
        byp_d   = '{32'h55, 32'h22, 32'h23};

        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        rst = 1'b1;
        idle();
`ifdef REGFILE_WRITEBACK_BYPASS_EN
        rr1 = '0; rr2 = '0;
`endif

        // Reset state
        tick(); tick();
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_wr", {27'd0, wr}, 32'd0);
        check("rst_wd", wd, 32'd0);
        check("rst_pend", {29'd0, pend_count}, 32'd0);
        check("rst_ready", {31'd0, lsu_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, lsu_ready}, 32'd1);

        // Single-cycle ALU vectors: write (or not) exactly one cycle after the edge
        for (int i = 0; i < 6; i++) begin
            idle();
            alu_valid = vecs[i].av; alu_rd = vecs[i].ar; alu_data = vecs[i].ad;
            if (vecs[i].exp_we) sb.push_back('{vecs[i].ar, vecs[i].ad});
            tick();
            check($sformatf("vec%0d_regwrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].exp_we});
            if (vecs[i].exp_we) check($sformatf("vec%0d_wr", i), {27'd0, wr}, {27'd0, vecs[i].ar});
        end
        idle();
        tick();
        check("alu_one_cycle", {31'd0, RegWrite}, 32'd0);
        check("rf5", model_rf[5], 32'hDEADBEEF);
        check("rf31", model_rf[31], 32'hFFFFFFFF);

        // Fill the FIFO under continuous ALU writes, then drain in order
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fill%0d_ready", k), {31'd0, lsu_ready}, 32'd1);
            drive_alu(5'(10 + k), 32'h100 + k, 1'b1);
            drive_lsu(5'(1 + k), 32'h200 + k);
            tick();
        end
        idle();
        check("full_pend", {29'd0, pend_count}, 32'd4);
        check("full_ready", {31'd0, lsu_ready}, 32'd0);
        for (int k = 0; k < 4; k++) sb.push_back('{5'(1 + k), 32'h200 + k});
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("drain%0d_regwrite", k), {31'd0, RegWrite}, 32'd1);
            check($sformatf("drain%0d_wr", k), {27'd0, wr}, 32'(1 + k));
        end
        tick();
        check("drained_regwrite", {31'd0, RegWrite}, 32'd0);
        check("drained_pend", {29'd0, pend_count}, 32'd0);

        // Buffered LSU rd=7 overtaken by a younger ALU write to rd=7
        drive_alu(5'd8, 32'h80, 1'b1);
        drive_lsu(5'd7, 32'h1);
        tick();
        idle();
        drive_alu(5'd7, 32'h2, 1'b1);
        tick();
        idle();
        check("kill_still_pending", {29'd0, pend_count}, 32'd1);
        tick();
        check("kill_dropped", {31'd0, RegWrite}, 32'd0);
        check("kill_popped", {29'd0, pend_count}, 32'd0);
        tick();
        check("rf7", model_rf[7], 32'h2);

        // Same-cycle LSU and ALU to rd=9: the ALU result wins
        drive_alu(5'd9, 32'hB, 1'b1);
        drive_lsu(5'd9, 32'hA);
        tick();
        idle();
        check("same_cycle_pend", {29'd0, pend_count}, 32'd1);
        tick();
        check("same_cycle_dropped", {31'd0, RegWrite}, 32'd0);
        check("same_cycle_popped", {29'd0, pend_count}, 32'd0);
        tick();
        check("rf9", model_rf[9], 32'hB);

        // rd=0 on both sides: handshake completes, nothing stored or written
        check("rd0_ready", {31'd0, lsu_ready}, 32'd1);
        drive_alu(5'd0, 32'h99, 1'b0);
        drive_lsu(5'd0, 32'h77);
        tick();
        idle();
        check("rd0_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rd0_pend", {29'd0, pend_count}, 32'd0);

        // ALU rd=0 lets the FIFO drain that cycle
        drive_alu(5'd14, 32'hE, 1'b1);
        drive_lsu(5'd12, 32'hC);
        tick();
        idle();
        drive_alu(5'd0, 32'h99, 1'b0);
        sb.push_back('{5'd12, 32'hC});
        tick();
        idle();
        check("alu0_drain_regwrite", {31'd0, RegWrite}, 32'd1);
        check("alu0_drain_wr", {27'd0, wr}, 32'd12);
        check("alu0_drain_wd", wd, 32'hC);

        // Three pending entries discarded by reset
        for (int k = 0; k < 3; k++) begin
            drive_alu(5'(15 + k), 32'h150 + k, 1'b1);
            drive_lsu(byp_rd[k], byp_d[k]);
            tick();
        end
        idle();
        check("pre_rst_pend", {29'd0, pend_count}, 32'd3);
`ifdef REGFILE_WRITEBACK_BYPASS_EN
        rr1 = 5'd6; rr2 = 5'd17;
        #1;
        check("byp1_hit", {31'd0, byp1_hit}, 32'd1);
        check("byp1_data", byp1_data, 32'h55);
        check("byp2_hit_out", {31'd0, byp2_hit}, 32'd1);
        check("byp2_data_out", byp2_data, 32'h152);
        rr1 = 5'd0; rr2 = 5'd9;
        #1;
        check("byp1_x0", {31'd0, byp1_hit}, 32'd0);
        check("byp2_miss", {31'd0, byp2_hit}, 32'd0);
        rr1 = '0; rr2 = '0;
`endif
        rst = 1'b1;
        tick();
        check("mid_rst_pend", {29'd0, pend_count}, 32'd0);
        check("mid_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("mid_rst_ready", {31'd0, lsu_ready}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("post_rst_pend", {29'd0, pend_count}, 32'd0);
        check("post_rst_regwrite", {31'd0, RegWrite}, 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
